// File: rtl/fp128_mul_result_queue_pkg.sv
// Shared types for the FP128 multiplier result queue: result word, flag struct, queue entry.
package fp128_mul_result_queue_pkg;

  localparam int FP128_W = 128;
  localparam int RQ_TAGW = 6;

  typedef logic [FP128_W-1:0] fp128_t;

  typedef struct packed {
    logic sign_exe;
    logic inf;
    logic overflow;
    logic underflow;
  } fp128_mul_flags_t;

  localparam int FLAGS_W = $bits(fp128_mul_flags_t);

  typedef struct packed {
    fp128_t               res;
    fp128_mul_flags_t     flags;
    logic [RQ_TAGW-1:0]   tag;
  } fp128_mul_rq_entry_t;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fp128_sync_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers (any DEPTH >= 1) and occupancy count.
module fp128_sync_fifo
  import fp128_mul_result_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_ok = rd_en & ~empty;
  // A write into a full FIFO is only accepted when a read frees the slot in the same cycle.
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_ok) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fp128_mul_result_queue.sv
// In-order result queue behind the FP128 multiplier with credit-based in_ready.
// Optional FP128_MUL_RQ_BYPASS_EN: empty-queue results are presented in their arrival cycle.
module fp128_mul_result_queue
  import fp128_mul_result_queue_pkg::*;
#(
  parameter int MUL_LAT = 10,
  parameter int DEPTH   = 12,
  parameter int TAGW    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAGW-1:0]            in_tag,
  input  logic [127:0]               res_i,
  input  logic [3:0]                 flags_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [127:0]               out_res,
  output logic [TAGW-1:0]            out_tag,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int ENTRY_W = FP128_W + FLAGS_W + TAGW;

  logic               issue, push;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [TAGW-1:0]    tag_q [MUL_LAT];
  logic [TAGW-1:0]    tag_d [MUL_LAT];
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW:0]        credit_used;
  fp128_mul_flags_t   push_flags;
  logic [ENTRY_W-1:0] push_entry, head_entry, fifo_rd_data;
  logic               fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               head_valid;

  assign issue = in_valid & in_ready;

  // Stage 1 takes the issue; stage MUL_LAT lines up with the result on res_i.
  for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign vld_d[gi] = issue;
      assign tag_d[gi] = in_tag;
    end else begin : g_body
      assign vld_d[gi] = vld_q[gi-1];
      assign tag_d[gi] = tag_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign push = vld_q[MUL_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  // Every issued op reserves a slot until popped, so a landing result always has room.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready    = ~rst & ~fifo_full & (credit_used < (CW+1)'(DEPTH));

  assign push_flags = fp128_mul_flags_t'(flags_i);
  assign push_entry = {res_i, push_flags, tag_q[MUL_LAT-1]};

  always_comb begin
    head_valid = ~fifo_empty;
    head_entry = fifo_rd_data;
    fifo_wr    = push;
    fifo_rd    = out_ready;
`ifdef FP128_MUL_RQ_BYPASS_EN
    if (fifo_empty && push) begin
      head_valid = 1'b1;
      head_entry = push_entry;
      fifo_wr    = ~out_ready;
      fifo_rd    = 1'b0;
    end
`endif
  end

  fp128_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (push_entry),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = ~rst & head_valid;
  assign out_res   = head_entry[ENTRY_W-1 -: FP128_W];
  assign out_flags = head_entry[TAGW +: FLAGS_W];
  assign out_tag   = head_entry[TAGW-1:0];
  assign count     = rst ? '0 : fifo_count;

endmodule

// File: tb/tb_fp128_mul_result_queue.sv
// Directed bench for fp128_mul_result_queue; the multiplier is a fixed-latency delay line of hand-computed products.
module tb_fp128_mul_result_queue;

  localparam int MUL_LAT = 10;
  localparam int DEPTH   = 12;
  localparam int TAGW    = 6;
  localparam int CW      = $clog2(DEPTH + 1);
`ifdef FP128_MUL_RQ_BYPASS_EN
  localparam int LAT_MIN = MUL_LAT;
`else
  localparam int LAT_MIN = MUL_LAT + 1;
`endif

  localparam logic [127:0] P_TWO   = {16'h4000, 112'h0};
  localparam logic [127:0] P_FOUR  = {16'h4001, 112'h0};
  localparam logic [127:0] P_THREE = {16'h4000, 16'h8000, 96'h0};
  localparam logic [127:0] P_MTWO  = {16'hC000, 112'h0};
  localparam logic [127:0] P_INF   = {16'h7FFF, 112'h0};

  typedef struct {
    logic [127:0]    res;
    logic [3:0]      flags;
    logic [TAGW-1:0] tag;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TAGW-1:0] in_tag = '0;
  logic [127:0]    res_i;
  logic [3:0]      flags_i;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [127:0]    out_res;
  logic [TAGW-1:0] out_tag;
  logic [3:0]      out_flags;
  logic [CW-1:0]   count;

  logic [131:0]    mul_in = '0;
  logic [131:0]    mul_pipe [MUL_LAT];

  exp_t exp_q[$];
  int n_total = 0, n_pass = 0;
  int cyc_now = 0, next_tag = 0, n_issued = 0, n_pops = 0, n_valid_cycles = 0;
  int first_valid_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, last_issue_cyc = -1;
  int max_count = 0;

  fp128_mul_result_queue #(
    .MUL_LAT (MUL_LAT),
    .DEPTH   (DEPTH),
    .TAGW    (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .res_i     (res_i),
    .flags_i   (flags_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: operands captured at the issue edge come out MUL_LAT edges later.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= mul_in;
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign res_i   = mul_pipe[MUL_LAT-1][131:4];
  assign flags_i = mul_pipe[MUL_LAT-1][3:0];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_now, got, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] tbl(input int i);
    case (i % 4)
      0:       return P_TWO;
      1:       return P_FOUR;
      2:       return P_THREE;
      default: return P_MTWO;
    endcase
  endfunction

  // One clock cycle: check credit/occupancy/head against the transaction model, then advance.
  task automatic tick();
    int   landed;
    bit   exp_ov;
    exp_t e;
    #1;
    chk("in_ready", in_ready, (!rst && exp_q.size() < DEPTH));
    landed = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc + MUL_LAT < cyc_now) landed++;
    chk("count", count, rst ? 0 : landed);
    exp_ov = !rst && exp_q.size() > 0 && (exp_q[0].cyc + LAT_MIN <= cyc_now);
    chk("out_valid", out_valid, exp_ov);
    if (int'(count) > max_count) max_count = int'(count);
    if (out_valid) begin
      n_valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc_now;
    end
    if (out_valid && out_ready) begin
      chk("pop_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_res", out_res, e.res);
        chk("pop_tag", out_tag, e.tag);
        chk("pop_flags", out_flags, e.flags);
        n_pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc_now;
        last_pop_cyc = cyc_now;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back('{mul_in[131:4], mul_in[3:0], in_tag, cyc_now});
      last_issue_cyc = cyc_now;
      n_issued++;
      next_tag++;
    end
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic step(input bit v, input bit r, input logic [127:0] res, input logic [3:0] fl);
    in_valid  = v;
    out_ready = r;
    in_tag    = TAGW'(next_tag);
    if (v) mul_in = {res, fl};
    else   mul_in = {$urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom())};
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) step(1'b0, 1'b1, '0, '0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input bit r);
    for (int k = 0; k < 40 && first_valid_cyc < 0; k++) step(1'b0, r, '0, '0);
  endtask

  initial begin
    int acc0, pops0, drops;

    // Reset
    step(1'b0, 1'b0, '0, '0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    step(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0, '0);
    chk("post_rst_in_ready", in_ready, 1);

    // 1: single issue, 1.0 * 2.0
    next_tag = 5;
    first_valid_cyc = -1;
    step(1'b1, 1'b0, P_TWO, 4'b0000);
    wait_valid(1'b0);
    chk("t1_latency", first_valid_cyc - last_issue_cyc, LAT_MIN);
    chk("t1_res", out_res, P_TWO);
    chk("t1_tag", out_tag, 5);
    chk("t1_flags", out_flags, 4'b0000);
    step(1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    chk("t1_count_after_pop", count, 0);

    // 2: MUL_LAT+4 back-to-back issues, consumer always ready
    next_tag = 0;
    max_count = 0;
    first_pop_cyc = -1;
    pops0 = n_pops;
    drops = 0;
    for (int i = 0; i < MUL_LAT + 4; i++) begin
      if (!in_ready) drops++;
      step(1'b1, 1'b1, tbl(next_tag), 4'b0000);
    end
    drain();
    chk("t2_ready_drops", drops, 0);
    chk("t2_pops", n_pops - pops0, MUL_LAT + 4);
    chk("t2_one_per_cycle", last_pop_cyc - first_pop_cyc, MUL_LAT + 3);
    chk("t2_max_count_le1", max_count <= 1, 1);

    // 3: fill with consumer stalled, then drain
    acc0 = n_issued;
    for (int k = 0; k < MUL_LAT + DEPTH + 4; k++) step(1'b1, 1'b0, tbl(next_tag), 4'b0000);
    chk("t3_accepts", n_issued - acc0, DEPTH);
    chk("t3_count_full", count, DEPTH);
    chk("t3_in_ready_low", in_ready, 0);
    step(1'b0, 1'b1, '0, '0);
    chk("t3_ready_after_pop", in_ready, 1);
    drain();

    // 4: max finite squared overflows to +inf
    first_valid_cyc = -1;
    step(1'b1, 1'b0, P_INF, 4'b0110);
    wait_valid(1'b0);
    chk("t4_overflow", out_flags[1], 1);
    chk("t4_inf", out_flags[2], 1);
    chk("t4_res", out_res, P_INF);
    step(1'b0, 1'b1, '0, '0);

    // 5: reset while results are in flight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, tbl(next_tag), 4'b0000);
    rst = 1'b1;
    step(1'b0, 1'b1, '0, '0);
    rst = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_count", count, 0);
    chk("t5_inflight", dut.inflight_q, 0);
    acc0 = n_valid_cycles;
    for (int k = 0; k < MUL_LAT + 3; k++) step(1'b0, 1'b1, '0, '0);
    chk("t5_no_out_valid", n_valid_cycles - acc0, 0);

    // 6: simultaneous push and pop at count = DEPTH-1 under continuous issue
    for (int k = 0; k < 60 && count != CW'(DEPTH - 1); k++) step(1'b1, 1'b0, tbl(next_tag), 4'b0000);
    step(1'b1, 1'b1, tbl(next_tag), 4'b0000);
    chk("t6_count_hold", count, DEPTH - 1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b1, tbl(next_tag), 4'b0000);
    drain();

`ifdef FP128_MUL_RQ_BYPASS_EN
    first_valid_cyc = -1;
    step(1'b1, 1'b1, P_FOUR, 4'b0000);
    wait_valid(1'b1);
    chk("t6b_latency", first_valid_cyc - last_issue_cyc, MUL_LAT);
    chk("t6b_count", count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_now);
    $fatal(1, "watchdog");
  end

endmodule
